// File: rtl/tag_trans_table_if.sv
// Lookup/update port bundle between the tag sorter, the tag storage memory
// and the tag-to-pointer translation table.
interface tag_trans_table_if #(
  parameter int N = 6,
  parameter int W = 4
);
  // Strobe semantics: rd_req and wr_req are single-cycle strobes sampled on the
  // rising clock edge. There is no ready or acknowledge, so every strobe is
  // accepted. rd_data is valid from the cycle after rd_req until the next read.
  logic         rd_req;
  logic [N-1:0] rd_addr;
  logic [W-1:0] rd_data;
  logic         wr_req;
  logic [N-1:0] wr_addr;
  logic [W-1:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/tag_trans_table.sv
// Direct-mapped tag -> storage-pointer table: 2**N registered entries,
// one-cycle registered read, write-first on a same-address collision.
module tag_trans_table #(
  parameter int N = 6,
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  tag_trans_table_if.slave  bus
);
  localparam int DEPTH = 1 << N;

  logic [W-1:0] entry [DEPTH];
  logic [W-1:0] rd_data_q;
  logic         collide;

  assign collide     = bus.wr_req && (bus.wr_addr == bus.rd_addr);
  assign bus.rd_data = rd_data_q;

  // Every entry carries a reset so that unwritten tags point at node 0, never X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (bus.wr_req) begin
        entry[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.rd_req) begin
        rd_data_q <= collide ? bus.wr_data : entry[bus.rd_addr];
      end
    end
  end
endmodule

// File: tb/tb_tag_trans_table.sv
// Self-checking bench for tag_trans_table: directed scenarios followed by
// random traffic, all compared against a plain array model of the table.
module tb_tag_trans_table;
  localparam int N = 6;
  localparam int W = 4;
  localparam int DEPTH = 1 << N;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tag_trans_table_if #(.N(N), .W(W)) bus ();

  tag_trans_table #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model and scoreboard
  logic [W-1:0] tbl [DEPTH];
  logic [W-1:0] model_rd;
  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    model_rd = '0;
    exp_q.delete();
  endtask

  task automatic idle();
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  // One clock cycle of traffic, started and finished on a falling edge.
  task automatic drive(input string tag, input logic rd, input logic [N-1:0] ra,
                       input logic wr, input logic [N-1:0] wa, input logic [W-1:0] wd);
    bus.rd_req  = rd;
    bus.rd_addr = ra;
    bus.wr_req  = wr;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    @(posedge clk);
    if (rd) begin
      model_rd = (wr && wa == ra) ? wd : tbl[ra];
      exp_q.push_back(model_rd);
    end
    if (wr) tbl[wa] = wd;
    @(negedge clk);
    if (rd) check(tag, bus.rd_data, exp_q.pop_front());
    else    check({tag, "_hold"}, bus.rd_data, model_rd);
  endtask

  task automatic read(input string tag, input logic [N-1:0] ra);
    drive(tag, 1'b1, ra, 1'b0, '0, '0);
  endtask

  task automatic write(input string tag, input logic [N-1:0] wa, input logic [W-1:0] wd);
    drive(tag, 1'b0, '0, 1'b1, wa, wd);
  endtask

  initial begin
    logic [N-1:0] ra, wa;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_rd_data", bus.rd_data, '0);
    rst = 1'b1;

    // asynchronous reset pulse in the middle of a cycle
    write("pre_rst_wr", 6'd10, 4'd3);
    read("pre_rst_rd", 6'd10);
    idle();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst_rd_data", bus.rd_data, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) read("post_rst_sweep", i[N-1:0]);

    // write then read, plus an untouched neighbour
    write("wr_1", 6'd1, 4'd5);
    read("rd_2_unwritten", 6'd2);
    read("rd_1", 6'd1);

    // hold: no reads for 10 cycles while entry 1 is overwritten
    write("hold_wr", 6'd1, 4'd9);
    for (int i = 0; i < 9; i++) drive("hold", 1'b0, '0, 1'b0, '0, '0);
    read("rd_1_after_hold", 6'd1);

    // same-address collision is write-first
    drive("collide", 1'b1, 6'd3, 1'b1, 6'd3, 4'd7);
    read("rd_3_after_collide", 6'd3);
    // different-address read and write in the same cycle
    drive("split_rdwr", 1'b1, 6'd1, 1'b1, 6'd2, 4'd11);
    read("rd_2_after_split", 6'd2);

    // full sweep, back-to-back writes then back-to-back reads
    for (int i = 0; i < DEPTH; i++) write("sweep_wr", i[N-1:0], i[W-1:0]);
    for (int i = 0; i < DEPTH; i++) read("sweep_rd", i[N-1:0]);

    // reset asserted in the same cycle as a write
    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 6'd4;
    bus.wr_data = 4'd6;
    #2 rst = 1'b0;
    #1 check("rst_mid_traffic_rd_data", bus.rd_data, '0);
    @(posedge clk);
    #1 check("rst_held_rd_data", bus.rd_data, '0);
    model_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    read("rd_4_after_rst", 6'd4);
    read("rd_5_after_rst", 6'd5);

    // random traffic, biased to a few addresses to provoke collisions
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 7)) : N'($urandom_range(0, DEPTH - 1));
      wa = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 7)) : N'($urandom_range(0, DEPTH - 1));
      drive("random", 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
            W'($urandom_range(0, (1 << W) - 1)));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
